// File: rtl/addsub_rr_sched_pkg.sv
// Shared definitions for the round-robin add/sub scheduler.
// Opcodes, FSM state encodings and the default datapath width.
package addsub_rr_sched_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/adder_sub.sv
// WIDTH-bit adder/subtractor with carry-in and carry-out.
// Subtract is a + ~b + cin; cin = 1 gives a true difference.
module adder_sub
    import addsub_rr_sched_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cnt,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    logic [WIDTH-1:0] b_eff;

    always_comb begin
        b_eff = b;
        unique case (cnt)
            OP_ADD:  b_eff = b;
            OP_SUB:  b_eff = ~b;
            default: b_eff = b;
        endcase
    end

    assign {cout, s} = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/addsub_rr_sched_rr_arbiter.sv
// Combinational round-robin winner select.
// Search starts one past ptr_i and wraps; the pointer lives in the caller.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req_valid_i,
    input  logic [ID_W-1:0]  ptr_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [ID_W-1:0]  idx_o
);

    logic            found;
    logic [ID_W-1:0] j;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        j       = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            j = ID_W'((int'(ptr_i) + k) % N_REQ);
            if (!found && req_valid_i[j]) begin
                found      = 1'b1;
                grant_o[j] = 1'b1;
                idx_o      = j;
            end
        end
    end

endmodule

// File: rtl/addsub_rr_sched.sv
// Round-robin scheduler sharing one adder_sub among N_REQ requesters.
// One op in flight: IDLE grants, EXEC computes, RESP holds the result.
module addsub_rr_sched
    import addsub_rr_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int ID_W  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    input  logic [N_REQ-1:0]       req_op,
    input  logic [N_REQ-1:0]       req_cin,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [WIDTH-1:0]       rsp_s,
    output logic                   rsp_cout,
    output logic [ID_W-1:0]        rsp_id
);

    state_e           state_q;
    logic [ID_W-1:0]  ptr_q;
    logic [ID_W-1:0]  id_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             op_q;
    logic             cin_q;
    logic             rsp_valid_q;
    logic [WIDTH-1:0] rsp_s_q;
    logic             rsp_cout_q;
    logic [ID_W-1:0]  rsp_id_q;

    logic [N_REQ-1:0] gnt;
    logic [ID_W-1:0]  gnt_idx;
    logic [WIDTH-1:0] a_arr [N_REQ];
    logic [WIDTH-1:0] b_arr [N_REQ];
    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] b_d;
    logic             op_d;
    logic             cin_d;
    logic [WIDTH-1:0] sum;
    logic             co;

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign a_arr[g] = req_a[g*WIDTH +: WIDTH];
        assign b_arr[g] = req_b[g*WIDTH +: WIDTH];
    end

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req_valid_i (req_valid),
        .ptr_i       (ptr_q),
        .grant_o     (gnt),
        .idx_o       (gnt_idx)
    );

    assign a_d   = a_arr[gnt_idx];
    assign b_d   = b_arr[gnt_idx];
    assign op_d  = req_op[gnt_idx];
    assign cin_d = req_cin[gnt_idx];

    // Held low during reset so no request is ever acknowledged then dropped.
    assign req_ready = (rst && state_q == ST_IDLE) ? gnt : '0;

    adder_sub #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .a    (a_q),
        .b    (b_q),
        .cnt  (op_q),
        .cin  (cin_q),
        .s    (sum),
        .cout (co)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= ID_W'(N_REQ - 1);
            id_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= 1'b0;
            cin_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_s_q     <= '0;
            rsp_cout_q  <= 1'b0;
            rsp_id_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|req_valid) begin
                        a_q     <= a_d;
                        b_q     <= b_d;
                        op_q    <= op_d;
                        cin_q   <= cin_d;
                        id_q    <= gnt_idx;
                        ptr_q   <= gnt_idx;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_s_q     <= sum;
                    rsp_cout_q  <= co;
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_s     = rsp_s_q;
    assign rsp_cout  = rsp_cout_q;
    assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_addsub_rr_sched.sv
// Self-checking bench for addsub_rr_sched with a response scoreboard.
// Expected results are queued at grant time and popped on each response.
module tb_addsub_rr_sched;
    import addsub_rr_sched_pkg::*;

    localparam int N = 4;
    localparam int W = 32;

    typedef struct packed {
        logic [1:0]   id;
        logic [W-1:0] s;
        logic         cout;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_op;
    logic [N-1:0]   req_cin;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [W-1:0]   rsp_s;
    logic           rsp_cout;
    logic [1:0]     rsp_id;

    logic [W-1:0] a_arr [N];
    logic [W-1:0] b_arr [N];

    assign req_a = {a_arr[3], a_arr[2], a_arr[1], a_arr[0]};
    assign req_b = {b_arr[3], b_arr[2], b_arr[1], b_arr[0]};

    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t sb[$];
    int   cyc    = 0;
    int   last_rsp;
    bit   prev_ok = 0;
    bit   gap_en  = 0;

    always #5 clk = ~clk;

    addsub_rr_sched #(
        .N_REQ (N),
        .WIDTH (W),
        .ID_W  (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .req_cin   (req_cin),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_s     (rsp_s),
        .rsp_cout  (rsp_cout),
        .rsp_id    (rsp_id)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic op, input logic cin);
        logic [W-1:0] bb;
        bb = (op == OP_ADD) ? b : ~b;
        return {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, cin};
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            sb.delete();
            prev_ok = 0;
        end else begin
            chk("ready_onehot", 64'($onehot0(req_ready)), 64'd1);
            for (int i = 0; i < N; i++) begin
                logic [1:0] ii;
                logic [W:0] r;
                exp_t e;
                ii = 2'(i);
                if (req_valid[ii] && req_ready[ii]) begin
                    r = model(a_arr[ii], b_arr[ii], req_op[ii], req_cin[ii]);
                    e.id = ii;
                    e.s = r[W-1:0];
                    e.cout = r[W];
                    sb.push_back(e);
                end
            end
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_s", 64'(rsp_s), 64'(e.s));
                    chk("sb_cout", 64'(rsp_cout), 64'(e.cout));
                    chk("sb_id", 64'(rsp_id), 64'(e.id));
                end
                if (gap_en) begin
                    if (prev_ok) chk("rsp_gap", 64'(cyc - last_rsp), 64'd3);
                    prev_ok = 1;
                    last_rsp = cyc;
                end else begin
                    prev_ok = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [1:0] i, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic op,
                           input logic cin);
        a_arr[i]     = a;
        b_arr[i]     = b;
        req_op[i]    = op;
        req_cin[i]   = cin;
        req_valid[i] = 1'b1;
    endtask

    task automatic wait_ready(input logic [1:0] i);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready[i] && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[i]) chk("ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 20);
        if (!rsp_valid) chk("rsp_timeout", 64'd0, 64'd1);
    endtask

    task automatic single(input string tag, input logic [1:0] i,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic op, input logic cin,
                          input logic [W-1:0] es, input logic ec,
                          input bit chk_lat);
        int n;
        tick();
        set_req(i, a, b, op, cin);
        wait_ready(i);
        if (chk_lat) chk({tag, "_ready"}, 64'(req_ready), 64'b0001);
        tick();
        req_valid[i] = 1'b0;
        wait_rsp(n);
        if (chk_lat) chk({tag, "_lat"}, 64'(n), 64'd2);
        chk({tag, "_s"}, 64'(rsp_s), 64'(es));
        chk({tag, "_cout"}, 64'(rsp_cout), 64'(ec));
        chk({tag, "_id"}, 64'(rsp_id), 64'(i));
    endtask

    initial begin
        int n;
        int g;
        logic [W-1:0] hold_s;
        rst       = 1'b0;
        req_valid = '0;
        req_op    = '0;
        req_cin   = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            a_arr[i] = '0;
            b_arr[i] = '0;
        end
        tick();
        tick();
        @(negedge clk);
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_valid", 64'(rsp_valid), 64'd0);
        chk("rst_s", 64'(rsp_s), 64'd0);
        chk("rst_cout", 64'(rsp_cout), 64'd0);
        chk("rst_id", 64'(rsp_id), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        single("add", 2'd0, 32'd5, 32'd3, 1'b0, 1'b0, 32'd8, 1'b0, 1);
        single("borrow", 2'd2, 32'd3, 32'd5, 1'b1, 1'b1,
               32'hFFFF_FFFE, 1'b0, 0);
        single("sub", 2'd2, 32'd5, 32'd3, 1'b1, 1'b1, 32'd2, 1'b1, 0);
        single("ovf", 2'd1, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0,
               32'd0, 1'b1, 0);

        tick();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        for (int i = 0; i < N; i++)
            set_req(2'(i), $urandom, $urandom, 1'($urandom), 1'($urandom));
        gap_en = 1;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            @(negedge clk);
            while (req_ready == '0 && n < 20) begin
                @(negedge clk);
                n++;
            end
            g = -1;
            for (int i = 0; i < N; i++)
                if (req_ready[2'(i)]) g = i;
            chk("rr_order", 64'(g), 64'(k % N));
            tick();
            if (k == 4) req_valid = '0;
            else if (g >= 0)
                set_req(2'(g), $urandom, $urandom, 1'($urandom),
                        1'($urandom));
        end
        repeat (4) tick();
        gap_en = 0;

        rsp_ready = 1'b0;
        set_req(2'd3, $urandom, $urandom, 1'b1, 1'b1);
        wait_ready(2'd3);
        tick();
        req_valid[3] = 1'b0;
        set_req(2'd1, 32'd100, 32'd23, 1'b0, 1'b1);
        wait_rsp(n);
        hold_s = rsp_s;
        chk("bp_id", 64'(rsp_id), 64'd3);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("bp_valid", 64'(rsp_valid), 64'd1);
            chk("bp_stable", 64'(rsp_s), 64'(hold_s));
            chk("bp_ready", 64'(req_ready), 64'd0);
        end
        tick();
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_next_grant", 64'(req_ready), 64'b0010);
        tick();
        req_valid[1] = 1'b0;
        repeat (4) tick();

        set_req(2'd0, 32'd7, 32'd9, 1'b0, 1'b0);
        wait_ready(2'd0);
        tick();
        req_valid[0] = 1'b0;
        rst = 1'b0;
        tick();
        @(negedge clk);
        chk("mid_rst_valid", 64'(rsp_valid), 64'd0);
        chk("mid_rst_s", 64'(rsp_s), 64'd0);
        chk("mid_rst_ready", 64'(req_ready), 64'd0);
        tick();
        set_req(2'd1, 32'd11, 32'd22, 1'b0, 1'b0);
        set_req(2'd3, 32'd50, 32'd8, 1'b1, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_first", 64'(req_ready), 64'b0010);
        tick();
        req_valid[1] = 1'b0;
        wait_ready(2'd3);
        chk("mid_rst_second", 64'(req_ready), 64'b1000);
        tick();
        req_valid[3] = 1'b0;
        repeat (5) tick();
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
